// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: 2-bit command encoding {J,K} and the
// reference next-state function used by the cells and by models.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  // Characteristic equation Q+ = J&~Q | ~K&Q, with jk = {J,K}
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    return (jk[1] & ~q) | (~jk[0] & q);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK stage built from a D flip-flop; resets to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // D flip-flop fed by the JK characteristic equation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= jk_next(q, {j, k});
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK cells. The J/K inputs of
// every bit are decoded from the current count, direction and load; the
// wrap and out-of-range-load pulses are registered alongside the cells.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is representable in the range compare
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_end;
  logic             in_range;
  logic [WIDTH-1:0] clamp_val;

  assign at_end    = up ? (q == MAX_VAL) : (q == '0);
  assign in_range  = ({1'b0, load_val} < MOD_EXT);
  assign clamp_val = in_range ? load_val : MAX_VAL;
  assign tc        = en & ~load & at_end;

  // Per-bit J/K decode: load > terminal-count wrap > ripple toggle > hold
  always_comb begin
    logic [1:0] cmd;
    logic       chain;
    j     = '0;
    k     = '0;
    cmd   = JK_HOLD;
    chain = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cmd = JK_HOLD;
      if (load) begin
        cmd = clamp_val[i] ? JK_SET : JK_RST;
      end else if (en) begin
        if (at_end)     cmd = (!up && MAX_VAL[i]) ? JK_SET : JK_RST;
        else if (chain) cmd = JK_TGL;
      end
      j[i]  = cmd[1];
      k[i]  = cmd[0];
      // Bit i+1 toggles only if every lower bit is 1 (up) or 0 (down)
      chain = chain & (up ? q[i] : ~q[i]);
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[gi]),
      .k     (k[gi]),
      .q     (q[gi])
    );
  end

  // Registered status pulses, one cycle after the causing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= load & ~in_range;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a MOD=10 and a MOD=16 instance share inputs.
// The driver pushes expected results into a queue; a monitor pops and checks.
module tb_jk_mod_counter;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  jk_mod_counter #(.WIDTH(4), .MOD(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  typedef struct {
    string      nm;
    logic [3:0] qa;
    logic       tca, wa, ea;
    logic [3:0] qb;
    logic       tcb, wb, eb;
  } item_t;

  item_t      sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] qa, qb;

  logic [3:0] up_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                            4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] dn_q [4]  = '{4'd1, 4'd0, 4'd9, 4'd8};
  logic       dn_tw[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  // Arithmetic reference; the target value is applied through jk_next per bit
  function automatic void model(input int mod, input logic [3:0] cur,
                                input logic e, u, l, input logic [3:0] lv,
                                output logic [3:0] nq, output logic ntc, nw, ne);
    logic [3:0] tgt;
    logic       at;
    at  = u ? (int'(cur) == mod - 1) : (cur == 4'd0);
    ntc = e & ~l & at;
    nw  = ntc;
    ne  = 1'b0;
    tgt = cur;
    if (l) begin
      if (int'(lv) < mod) tgt = lv;
      else begin
        tgt = 4'(mod - 1);
        ne  = 1'b1;
      end
    end else if (e) begin
      if (u) tgt = at ? 4'd0 : cur + 4'd1;
      else   tgt = at ? 4'(mod - 1) : cur - 4'd1;
    end
    for (int i = 0; i < 4; i++)
      nq[i] = jk_next(cur[i], (tgt[i] ^ cur[i]) ? JK_TGL : JK_HOLD);
  endfunction

  // Drive one cycle of stimulus and queue the expected response
  task automatic issue(input string nm, input logic e, u, l, input logic [3:0] lv,
                       input bit hand, input logic [3:0] hq, input logic htc, hw, he);
    item_t      it;
    logic [3:0] nqa, nqb;
    logic       ta, wa, ea, tb, wb, eb;
    model(10, qa, e, u, l, lv, nqa, ta, wa, ea);
    model(16, qb, e, u, l, lv, nqb, tb, wb, eb);
    it.nm  = nm;
    it.qa  = hand ? hq  : nqa;
    it.tca = hand ? htc : ta;
    it.wa  = hand ? hw  : wa;
    it.ea  = hand ? he  : ea;
    it.qb  = nqb;
    it.tcb = tb;
    it.wb  = wb;
    it.eb  = eb;
    en = e; up = u; load = l; load_val = lv;
    sb.push_back(it);
    qa = nqa;
    qb = nqb;
    @(posedge clk); #2;
  endtask

  // Monitor: tc before the edge, registered outputs just after it
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk({it.nm, "_tc_a"}, int'(tc_a), int'(it.tca));
        chk({it.nm, "_tc_b"}, int'(tc_b), int'(it.tcb));
        @(posedge clk); #1;
        chk({it.nm, "_q_a"},    int'(q_a),    int'(it.qa));
        chk({it.nm, "_wrap_a"}, int'(wrap_a), int'(it.wa));
        chk({it.nm, "_err_a"},  int'(err_a),  int'(it.ea));
        chk({it.nm, "_q_b"},    int'(q_b),    int'(it.qb));
        chk({it.nm, "_wrap_b"}, int'(wrap_b), int'(it.wb));
        chk({it.nm, "_err_b"},  int'(err_b),  int'(it.eb));
        chk({it.nm, "_range_a"}, int'(q_a < 4'd10), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    qa = 4'd0; qb = 4'd0;
    #3;
    chk("reset_q_a", int'(q_a), 0);
    chk("reset_wrap_a", int'(wrap_a), 0);
    chk("reset_err_a", int'(err_a), 0);
    chk("reset_q_b", int'(q_b), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      issue("up_wrap", 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, up_q[i], (i == 9), (i == 9), 1'b0);

    for (int i = 0; i < 4; i++)
      issue("down_wrap", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, dn_q[i], dn_tw[i], dn_tw[i], 1'b0);

    issue("load5",    1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    issue("load12",   1'b1, 1'b1, 1'b1, 4'd12, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    issue("err_once", 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b0, 1'b0, 1'b0);

    issue("load4", 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      issue("hold", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    issue("dir_up",   1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    issue("dir_down", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    issue("dir_up",   1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    issue("dir_down", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);

    issue("load6", 1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    issue("to7",   1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_q_a", int'(q_a), 0);
    chk("midrst_wrap_a", int'(wrap_a), 0);
    chk("midrst_err_a", int'(err_a), 0);
    chk("midrst_q_b", int'(q_b), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    qa = 4'd0;
    qb = 4'd0;
    issue("post_rst", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

    issue("load15", 1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    issue("wrap16", 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++)
      issue("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    en = 1'b0; load = 1'b0;
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
